// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the
// pipelined RV32I core.
//
// Holds the fetch PC, drives the instruction-memory req/ready handshake,
// applies CU redirects (jorbranch) and load-use stalls, and presents
// IR/PC/PC+4 to decode. A one-entry skid buffer catches an instruction that
// returns during a stall; a squash state discards a fetch that was
// outstanding when a redirect arrived.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   jorbranch[1:0]           00/11 sequential, 01 branch/JAL, 10 JALR
//   branch_target[31:0]      branch/JAL target
//   jalr_target[31:0]        JALR target (bit 0 cleared internally)
//   stall                    load-use hazard: hold IF/ID
//   imem_req, imem_addr      fetch request / word-aligned address
//   imem_ready, imem_rdata   transfer completion / returned instruction
//   if_id_ir, if_id_pc, if_id_pc4, if_id_valid   IF/ID register to decode
//   fetch_misalign           only with FETCH_MISALIGN_DET_EN: one-cycle pulse
//                            after a redirect to a misaligned target
//
// Optional feature macro: FETCH_MISALIGN_DET_EN
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  jorbranch,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef FETCH_MISALIGN_DET_EN
  ,
  output logic        fetch_misalign
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HOLD,
    ST_SQUASH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] rpc_q, rpc_d;
  logic [31:0] skid_ir_q, skid_ir_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        vld_q, vld_d;

  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;

  always_comb begin
    redirect   = (jorbranch == 2'b01) || (jorbranch == 2'b10);
    raw_target = (jorbranch == 2'b10) ? (jalr_target & 32'hFFFF_FFFE) : branch_target;
    target     = raw_target & 32'hFFFF_FFFC;
  end

  assign imem_req  = (state_q != ST_HOLD);
  assign imem_addr = fetch_q;

  always_comb begin
    state_d   = state_q;
    fetch_d   = fetch_q;
    rpc_d     = rpc_q;
    skid_ir_d = skid_ir_q;
    skid_pc_d = skid_pc_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    pc4_d     = pc4_q;
    vld_d     = vld_q;

    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          ir_d  = NOP_INSTR;
          vld_d = 1'b0;
          if (imem_ready) begin
            fetch_d = target;
          end else begin
            rpc_d   = target;
            state_d = ST_SQUASH;
          end
        end else if (imem_ready) begin
          fetch_d = fetch_q + 32'd4;
          if (!stall) begin
            ir_d  = imem_rdata;
            pc_d  = fetch_q;
            pc4_d = fetch_q + 32'd4;
            vld_d = 1'b1;
          end else begin
            // Decode is stalled: park the returned word so it is not lost.
            skid_ir_d = imem_rdata;
            skid_pc_d = fetch_q;
            state_d   = ST_HOLD;
          end
        end else if (!stall) begin
          ir_d  = NOP_INSTR;
          vld_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          ir_d    = NOP_INSTR;
          vld_d   = 1'b0;
          fetch_d = target;
          state_d = ST_RUN;
        end else if (!stall) begin
          ir_d    = skid_ir_q;
          pc_d    = skid_pc_q;
          pc4_d   = skid_pc_q + 32'd4;
          vld_d   = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_SQUASH: begin
        // The outstanding fetch must complete at its original address; its
        // data is wrong-path and never enters IF/ID.
        ir_d  = NOP_INSTR;
        vld_d = 1'b0;
        if (redirect) rpc_d = target;
        if (imem_ready) begin
          fetch_d = redirect ? target : rpc_q;
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      fetch_q   <= RESET_PC;
      rpc_q     <= RESET_PC;
      skid_ir_q <= '0;
      skid_pc_q <= '0;
      ir_q      <= NOP_INSTR;
      pc_q      <= '0;
      pc4_q     <= 32'd4;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetch_q   <= fetch_d;
      rpc_q     <= rpc_d;
      skid_ir_q <= skid_ir_d;
      skid_pc_q <= skid_pc_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      pc4_q     <= pc4_d;
      vld_q     <= vld_d;
    end
  end

  assign if_id_ir    = ir_q;
  assign if_id_pc    = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = vld_q;

`ifdef FETCH_MISALIGN_DET_EN
  logic misaligned;

  // JALR bit 0 is architecturally ignored, so only bit 1 counts there.
  assign misaligned = raw_target[1] | ((jorbranch == 2'b01) & raw_target[0]);

  always_ff @(posedge clk) begin
    if (rst) fetch_misalign <= 1'b0;
    else     fetch_misalign <= redirect & misaligned;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed stimulus with a scoreboard of expected
// IF/ID contents, pushed when a cycle's inputs are driven and popped after
// the clock edge that produces them.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  jorbranch;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_MISALIGN_DET_EN
  logic        fetch_misalign;
`endif

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jorbranch    (jorbranch),
    .branch_target(branch_target),
    .jalr_target  (jalr_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_id_ir     (if_id_ir),
    .if_id_pc     (if_id_pc),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
`ifdef FETCH_MISALIGN_DET_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: each word encodes its own address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = memword(imem_addr);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock cycle: check the fetch interface, drive inputs, queue the
  // IF/ID contents expected after the edge, then compare them.
  task automatic step(input logic [1:0] jb, input logic [31:0] bt, input logic [31:0] jt,
                      input logic st, input logic rdy, input logic ereq,
                      input logic [31:0] eaddr, input logic evalid, input logic [31:0] epc);
    exp_t e;
    chk("imem_req", {31'b0, imem_req}, {31'b0, ereq});
    chk("imem_addr", imem_addr, eaddr);
    jorbranch     = jb;
    branch_target = bt;
    jalr_target   = jt;
    stall         = st;
    imem_ready    = rdy;
    e.valid = evalid;
    e.pc    = epc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
    if (e.valid) begin
      chk("if_id_pc", if_id_pc, e.pc);
      chk("if_id_pc4", if_id_pc4, e.pc + 32'd4);
      chk("if_id_ir", if_id_ir, memword(e.pc));
    end else begin
      chk("if_id_ir_bubble", if_id_ir, NOP);
    end
  endtask

  task automatic seq(input logic st, input logic rdy, input logic ereq,
                     input logic [31:0] eaddr, input logic evalid, input logic [31:0] epc);
    step(2'b00, 32'h0, 32'h0, st, rdy, ereq, eaddr, evalid, epc);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    jorbranch  = 2'b00;
    stall      = 1'b0;
    imem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ir", if_id_ir, NOP);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h4);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_DET_EN
    chk("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
`endif
  endtask

  initial begin
    rst           = 1'b1;
    jorbranch     = 2'b00;
    branch_target = '0;
    jalr_target   = '0;
    stall         = 1'b0;
    imem_ready    = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Sequential fetch, ready tied high.
    seq(1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h00);
    seq(1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h04);
    seq(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h08);
    seq(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0C);

    // Load-use stall for two cycles while 0x10 returns.
    seq(1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C);
    seq(1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 32'h0C);
    seq(1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 32'h10);
    seq(1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h14);
    // Stall with no data returning: IF/ID held.
    seq(1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h14);

    // Taken branch with ready.
    step(2'b01, 32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 32'h18, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100);

    // JALR to 0x203 while the fetch at 0x20 is outstanding.
    step(2'b01, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0);
    step(2'b10, 32'h0, 32'h203, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    seq(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);

    // Redirect beats stall, then a second redirect in SQUASH wins.
    step(2'b01, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 32'h204, 1'b0, 32'h0);
    step(2'b01, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 32'h204, 1'b0, 32'h0);
    seq(1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400);

    // Redirect arriving in the same cycle SQUASH completes.
    step(2'b10, 32'h0, 32'h500, 1'b0, 1'b0, 1'b1, 32'h404, 1'b0, 32'h0);
    step(2'b01, 32'h600, 32'h0, 1'b0, 1'b1, 1'b1, 32'h404, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b1, 32'h600, 1'b1, 32'h600);

    // Redirect in HOLD drops the skid entry.
    seq(1'b1, 1'b1, 1'b1, 32'h604, 1'b1, 32'h600);
    step(2'b01, 32'h700, 32'h0, 1'b1, 1'b1, 1'b0, 32'h608, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b1, 32'h700, 1'b1, 32'h700);

    // Address wrap.
    step(2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 1'b1, 32'h704, 1'b0, 32'h0);
    seq(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
    seq(1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0);

    // Reset while in SQUASH.
    step(2'b01, 32'h800, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
    do_reset();
    seq(1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0);

    // Reset while in HOLD.
    seq(1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0);
    do_reset();
    seq(1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0);

    // Not ready, not stalled: bubble.
    seq(1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);

    // Misaligned branch target 0x102 fetches 0x100.
    step(2'b01, 32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_DET_EN
    chk("misalign_pulse", {31'b0, fetch_misalign}, 32'h1);
`endif
    seq(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100);
`ifdef FETCH_MISALIGN_DET_EN
    chk("misalign_clear", {31'b0, fetch_misalign}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
